// File: rtl/reg_file_stack.sv
// Context-save stack for the register file: pushes a nine-register frame at the
// external stack pointer and continuously presents the frame just below it.
module reg_file_stack #(
    parameter int PC_WIDTH = 5,
    parameter int WIDTH    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_WIDTH-1:0] addr,
    input  logic                wren,
    input  logic [WIDTH-1:0]    reg1_data,
    input  logic [WIDTH-1:0]    reg2_data,
    input  logic [WIDTH-1:0]    reg3_data,
    input  logic [WIDTH-1:0]    reg4_data,
    input  logic [WIDTH-1:0]    reg5_data,
    input  logic [WIDTH-1:0]    reg6_data,
    input  logic [WIDTH-1:0]    reg7_data,
    input  logic [WIDTH-1:0]    reg8_data,
    input  logic [WIDTH-1:0]    reg9_data,
    output logic [WIDTH-1:0]    stack1_out,
    output logic [WIDTH-1:0]    stack2_out,
    output logic [WIDTH-1:0]    stack3_out,
    output logic [WIDTH-1:0]    stack4_out,
    output logic [WIDTH-1:0]    stack5_out,
    output logic [WIDTH-1:0]    stack6_out,
    output logic [WIDTH-1:0]    stack7_out,
    output logic [WIDTH-1:0]    stack8_out,
    output logic [WIDTH-1:0]    stack9_out
);

    localparam int DEPTH   = 2 ** PC_WIDTH;
    localparam int FRAME_W = 9 * WIDTH;

    logic [FRAME_W-1:0]  mem [DEPTH];
    logic [FRAME_W-1:0]  wr_frame;
    logic [FRAME_W-1:0]  rd_frame;
    logic [PC_WIDTH-1:0] addr_below;

    assign wr_frame = {reg1_data, reg2_data, reg3_data, reg4_data, reg5_data,
                       reg6_data, reg7_data, reg8_data, reg9_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wren) begin
            mem[addr] <= wr_frame;
        end
    end

    // Top of stack is entry[addr-1]; an empty stack (addr==0) reads zero
    // rather than wrapping to the last entry.
    assign addr_below = addr - PC_WIDTH'(1);

    always_comb begin
        rd_frame = '0;
        if (addr != '0) begin
            rd_frame = mem[addr_below];
        end
    end

    assign {stack1_out, stack2_out, stack3_out, stack4_out, stack5_out,
            stack6_out, stack7_out, stack8_out, stack9_out} = rd_frame;

endmodule

// File: tb/tb_reg_file_stack.sv
// Directed self-checking bench for reg_file_stack: push/read, nesting, reset,
// idle, same-edge push and top-entry behaviour.
module tb_reg_file_stack;

    logic       clk;
    logic       rst_n;
    logic [4:0] addr;
    logic       wren;
    logic [7:0] reg1_data, reg2_data, reg3_data, reg4_data, reg5_data;
    logic [7:0] reg6_data, reg7_data, reg8_data, reg9_data;
    logic [7:0] stack1_out, stack2_out, stack3_out, stack4_out, stack5_out;
    logic [7:0] stack6_out, stack7_out, stack8_out, stack9_out;
    logic [71:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_stack #(.PC_WIDTH(5), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wren(wren),
        .reg1_data(reg1_data), .reg2_data(reg2_data), .reg3_data(reg3_data),
        .reg4_data(reg4_data), .reg5_data(reg5_data), .reg6_data(reg6_data),
        .reg7_data(reg7_data), .reg8_data(reg8_data), .reg9_data(reg9_data),
        .stack1_out(stack1_out), .stack2_out(stack2_out), .stack3_out(stack3_out),
        .stack4_out(stack4_out), .stack5_out(stack5_out), .stack6_out(stack6_out),
        .stack7_out(stack7_out), .stack8_out(stack8_out), .stack9_out(stack9_out)
    );

    assign obs = {stack1_out, stack2_out, stack3_out, stack4_out, stack5_out,
                  stack6_out, stack7_out, stack8_out, stack9_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] frame(input logic [7:0] b);
        return {9{b}};
    endfunction

    task automatic set_frame(input logic [71:0] f);
        {reg1_data, reg2_data, reg3_data, reg4_data, reg5_data,
         reg6_data, reg7_data, reg8_data, reg9_data} = f;
    endtask

    task automatic push(input logic [4:0] a, input logic [71:0] f);
        @(negedge clk);
        addr = a;
        set_frame(f);
        wren = 1'b1;
        @(posedge clk);
        #1;
        wren = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [71:0] exp);
        addr = a;
        #1;
        check(tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = '0;
        wren  = 1'b0;
        set_frame('0);
        #12;
        read_chk("por_addr1", 5'd1, '0);
        read_chk("por_addr31", 5'd31, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // single frame push / read
        push(5'd0, {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19});
        read_chk("single_addr0", 5'd0, '0);
        read_chk("single_addr1", 5'd1,
                 {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19});

        // nested frames
        push(5'd0, frame(8'hAA));
        push(5'd1, frame(8'h55));
        read_chk("nest_addr2", 5'd2, frame(8'h55));
        read_chk("nest_addr1", 5'd1, frame(8'hAA));
        read_chk("nest_addr0", 5'd0, '0);

        // preload the whole stack, then reset mid-cycle
        for (int i = 0; i < 32; i++) begin
            push(5'(i), frame(8'(i + 1)));
        end
        read_chk("preload_addr31", 5'd31, frame(8'd31));
        read_chk("preload_addr5", 5'd5, frame(8'd5));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_addr5", obs, '0);
        for (int i = 1; i < 32; i++) begin
            read_chk($sformatf("rst_addr%0d", i), 5'(i), '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        read_chk("post_rst_addr3", 5'd3, '0);

        // push coinciding with reset is discarded
        @(negedge clk);
        addr = 5'd0;
        set_frame(frame(8'hEE));
        wren = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        wren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        read_chk("rst_push_discard", 5'd1, '0);

        // idle: wren=0 must not write
        @(negedge clk);
        addr = 5'd0;
        set_frame(frame(8'hFF));
        wren = 1'b0;
        @(posedge clk);
        #1;
        read_chk("idle_no_write", 5'd1, '0);

        // same-edge push and read
        push(5'd1, frame(8'h33));
        @(negedge clk);
        addr = 5'd2;
        set_frame(frame(8'h77));
        wren = 1'b1;
        #1;
        check("same_edge_before", obs, frame(8'h33));
        @(posedge clk);
        #1;
        check("same_edge_after", obs, frame(8'h33));
        wren = 1'b0;
        read_chk("same_edge_addr3", 5'd3, frame(8'h77));

        // top entry
        push(5'd0, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09});
        push(5'd30, frame(8'h5A));
        push(5'd31, frame(8'hC3));
        read_chk("top_addr31", 5'd31, frame(8'h5A));
        read_chk("top_entry0_kept", 5'd1,
                 {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09});
        read_chk("top_addr0_empty", 5'd0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
